// File: rtl/iommu_msi_ptw.sv
// iommu_msi_ptw - MSI address-translation walker for the IOMMU translation path.
//
// Takes one guest-physical write address plus the extended device-context MSI
// fields (msiptp, msi_addr_mask, msi_addr_pattern) and decides whether the
// address targets a virtual interrupt file. If it does, the 16-byte MSI PTE is
// fetched and checked, and a supervisor-physical address (or a fault CAUSE) is
// returned. Otherwise a pass-through result hands the request to stage-2.
//
// Optional feature macro: MSI_MRIF_EN
//   defined   : MRIF-mode PTEs are supported (second doubleword fetch).
//   undefined : MRIF-mode PTEs fault with cause 263; MRIF outputs are tied 0.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   req_gpaddr_i, req_is_store_i request address and write/AMO flag
//   msiptp_i, msi_addr_mask_i,
//   msi_addr_pattern_i           device-context MSI fields
//   mem_req_* / mem_rsp_*        PTE doubleword read port (one rsp per req)
//   rsp_valid_o / rsp_ready_i    result handshake
//   rsp_is_msi_o, rsp_spaddr_o,
//   rsp_mrif_o, rsp_nppn_o,
//   rsp_nid_o, rsp_fault_o,
//   rsp_cause_o                  result fields
module iommu_msi_ptw #(
    parameter int         PLEN          = 56,
    parameter logic [3:0] MSI_MODE_FLAT = 4'd1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [PLEN-1:0] req_gpaddr_i,
    input  logic            req_is_store_i,
    input  logic [63:0]     msiptp_i,
    input  logic [63:0]     msi_addr_mask_i,
    input  logic [63:0]     msi_addr_pattern_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [PLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [63:0]     mem_rsp_data_i,
    input  logic            mem_rsp_err_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_is_msi_o,
    output logic [PLEN-1:0] rsp_spaddr_o,
    output logic            rsp_mrif_o,
    output logic [PLEN-13:0] rsp_nppn_o,
    output logic [10:0]     rsp_nid_o,
    output logic            rsp_fault_o,
    output logic [11:0]     rsp_cause_o
);

    localparam int PPN_W = PLEN - 12;
    localparam int IDX_W = $clog2(PPN_W + 1);

    localparam logic [11:0] CAUSE_DDT_MISCFG   = 12'd259;
    localparam logic [11:0] CAUSE_PT_ACCESS    = 12'd261;
    localparam logic [11:0] CAUSE_PTE_INVALID  = 12'd262;
    localparam logic [11:0] CAUSE_PTE_MISCFG   = 12'd263;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD0, S_WT0, S_RD1, S_WT1, S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             mem_req_valid_q, mem_req_valid_d;
    logic [PLEN-1:0]  mem_req_addr_q, mem_req_addr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_is_msi_q, rsp_is_msi_d;
    logic [PLEN-1:0]  rsp_spaddr_q, rsp_spaddr_d;
    logic             rsp_fault_q, rsp_fault_d;
    logic [11:0]      rsp_cause_q, rsp_cause_d;

    // Captured request and device-context fields.
    logic [PLEN-1:0]  gpaddr_q, gpaddr_d;
    logic             is_store_q, is_store_d;
    logic [3:0]       mode_q, mode_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;
    logic [PPN_W-1:0] mask_q, mask_d;
    logic [PPN_W-1:0] pattern_q, pattern_d;

`ifdef MSI_MRIF_EN
    logic             rsp_mrif_q, rsp_mrif_d;
    logic [PPN_W-1:0] rsp_nppn_q, rsp_nppn_d;
    logic [10:0]      rsp_nid_q, rsp_nid_d;
    logic [PLEN-10:0] mrif_ppn_q, mrif_ppn_d;
`endif

    // Result staging: any state that finishes the walk fills these and the
    // common tail below turns them into the registered response.
    logic             fin;
    logic [11:0]      fin_cause;
    logic             fin_msi;
    logic [PLEN-1:0]  fin_addr;
    logic             fin_mrif;
    logic [PPN_W-1:0] fin_nppn;
    logic [10:0]      fin_nid;

    logic [PPN_W-1:0] gpn;
    logic [PPN_W-1:0] imsic_num;
    logic [IDX_W-1:0] pos;
    logic             pass_through;
    logic [PLEN-1:0]  pte_addr;
    logic             wt_rsvd_bad;
    logic             mrif_rsvd_bad;

    assign gpn = gpaddr_q[PLEN-1:12];

    // Gather the masked GPN bits into contiguous LSBs, lowest mask bit first.
    always_comb begin
        imsic_num = '0;
        pos       = '0;
        for (int i = 0; i < PPN_W; i++) begin
            if (mask_q[i]) begin
                imsic_num[pos] = gpn[i];
                pos            = pos + IDX_W'(1);
            end
        end
    end

    assign pass_through = (mode_q == 4'd0) || !is_store_q ||
                          ((gpn & ~mask_q) != (pattern_q & ~mask_q));

    // Each PTE is 16 bytes; the sum wraps silently at PLEN.
    assign pte_addr = {ppn_q, 12'h000} + PLEN'({imsic_num, 4'h0});

    // Write-through dword0: reserved [9:3], reserved [62:54], C [63].
    assign wt_rsvd_bad = (|mem_rsp_data_i[9:3]) || (|mem_rsp_data_i[62:54]) ||
                         mem_rsp_data_i[63];
    // MRIF dword0: address field occupies [50:4], leaving [3] and [62:51].
    assign mrif_rsvd_bad = mem_rsp_data_i[3] || (|mem_rsp_data_i[62:51]) ||
                           mem_rsp_data_i[63];

    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_is_msi_d    = rsp_is_msi_q;
        rsp_spaddr_d    = rsp_spaddr_q;
        rsp_fault_d     = rsp_fault_q;
        rsp_cause_d     = rsp_cause_q;
        gpaddr_d        = gpaddr_q;
        is_store_d      = is_store_q;
        mode_d          = mode_q;
        ppn_d           = ppn_q;
        mask_d          = mask_q;
        pattern_d       = pattern_q;
`ifdef MSI_MRIF_EN
        rsp_mrif_d      = rsp_mrif_q;
        rsp_nppn_d      = rsp_nppn_q;
        rsp_nid_d       = rsp_nid_q;
        mrif_ppn_d      = mrif_ppn_q;
`endif
        fin       = 1'b0;
        fin_cause = 12'd0;
        fin_msi   = 1'b0;
        fin_addr  = '0;
        fin_mrif  = 1'b0;
        fin_nppn  = '0;
        fin_nid   = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    gpaddr_d    = req_gpaddr_i;
                    is_store_d  = req_is_store_i;
                    mode_d      = msiptp_i[63:60];
                    ppn_d       = msiptp_i[PPN_W-1:0];
                    mask_d      = msi_addr_mask_i[PPN_W-1:0];
                    pattern_d   = msi_addr_pattern_i[PPN_W-1:0];
                    req_ready_d = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (pass_through) begin
                    fin      = 1'b1;
                    fin_addr = gpaddr_q;
                end else if (mode_q != MSI_MODE_FLAT) begin
                    fin       = 1'b1;
                    fin_cause = CAUSE_DDT_MISCFG;
                end else begin
                    mem_req_addr_d  = pte_addr;
                    mem_req_valid_d = 1'b1;
                    state_d         = S_RD0;
                end
            end
            S_RD0: begin
                if (mem_req_ready_i) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = S_WT0;
                end
            end
            S_WT0: begin
                if (mem_rsp_valid_i) begin
                    if (mem_rsp_err_i) begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_PT_ACCESS;
                    end else if (!mem_rsp_data_i[0]) begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_PTE_INVALID;
                    end else if (mem_rsp_data_i[2:1] == 2'b11) begin
                        fin = 1'b1;
                        if (wt_rsvd_bad) begin
                            fin_cause = CAUSE_PTE_MISCFG;
                        end else begin
                            fin_msi  = 1'b1;
                            fin_addr = {mem_rsp_data_i[10 +: PPN_W], gpaddr_q[11:0]};
                        end
`ifdef MSI_MRIF_EN
                    end else if (mem_rsp_data_i[2:1] == 2'b01) begin
                        if (mrif_rsvd_bad) begin
                            fin       = 1'b1;
                            fin_cause = CAUSE_PTE_MISCFG;
                        end else begin
                            mrif_ppn_d      = mem_rsp_data_i[4 +: PLEN-9];
                            mem_req_addr_d  = mem_req_addr_q + PLEN'(8);
                            mem_req_valid_d = 1'b1;
                            state_d         = S_RD1;
                        end
`endif
                    end else begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_PTE_MISCFG;
                    end
                end
            end
`ifdef MSI_MRIF_EN
            S_RD1: begin
                if (mem_req_ready_i) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = S_WT1;
                end
            end
            S_WT1: begin
                if (mem_rsp_valid_i) begin
                    fin = 1'b1;
                    if (mem_rsp_err_i) begin
                        fin_cause = CAUSE_PT_ACCESS;
                    end else if ((|mem_rsp_data_i[59:54]) || (|mem_rsp_data_i[63:61])) begin
                        fin_cause = CAUSE_PTE_MISCFG;
                    end else begin
                        fin_msi  = 1'b1;
                        fin_mrif = 1'b1;
                        fin_addr = {mrif_ppn_q, 9'h000};
                        fin_nppn = mem_rsp_data_i[10 +: PPN_W];
                        fin_nid  = {mem_rsp_data_i[60], mem_rsp_data_i[9:0]};
                    end
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Faults always report zero address and no MSI/MRIF indication.
        if (fin) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_fault_d  = (fin_cause != 12'd0);
            rsp_cause_d  = fin_cause;
            rsp_is_msi_d = (fin_cause == 12'd0) && fin_msi;
            rsp_spaddr_d = (fin_cause == 12'd0) ? fin_addr : '0;
`ifdef MSI_MRIF_EN
            rsp_mrif_d   = (fin_cause == 12'd0) && fin_mrif;
            rsp_nppn_d   = (fin_cause == 12'd0) ? fin_nppn : '0;
            rsp_nid_d    = (fin_cause == 12'd0) ? fin_nid : '0;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_is_msi_q    <= 1'b0;
            rsp_spaddr_q    <= '0;
            rsp_fault_q     <= 1'b0;
            rsp_cause_q     <= '0;
            gpaddr_q        <= '0;
            is_store_q      <= 1'b0;
            mode_q          <= '0;
            ppn_q           <= '0;
            mask_q          <= '0;
            pattern_q       <= '0;
`ifdef MSI_MRIF_EN
            rsp_mrif_q      <= 1'b0;
            rsp_nppn_q      <= '0;
            rsp_nid_q       <= '0;
            mrif_ppn_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_is_msi_q    <= rsp_is_msi_d;
            rsp_spaddr_q    <= rsp_spaddr_d;
            rsp_fault_q     <= rsp_fault_d;
            rsp_cause_q     <= rsp_cause_d;
            gpaddr_q        <= gpaddr_d;
            is_store_q      <= is_store_d;
            mode_q          <= mode_d;
            ppn_q           <= ppn_d;
            mask_q          <= mask_d;
            pattern_q       <= pattern_d;
`ifdef MSI_MRIF_EN
            rsp_mrif_q      <= rsp_mrif_d;
            rsp_nppn_q      <= rsp_nppn_d;
            rsp_nid_q       <= rsp_nid_d;
            mrif_ppn_q      <= mrif_ppn_d;
`endif
        end
    end

    assign req_ready_o     = req_ready_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = mem_req_addr_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_is_msi_o    = rsp_is_msi_q;
    assign rsp_spaddr_o    = rsp_spaddr_q;
    assign rsp_fault_o     = rsp_fault_q;
    assign rsp_cause_o     = rsp_cause_q;
`ifdef MSI_MRIF_EN
    assign rsp_mrif_o      = rsp_mrif_q;
    assign rsp_nppn_o      = rsp_nppn_q;
    assign rsp_nid_o       = rsp_nid_q;
`else
    assign rsp_mrif_o      = 1'b0;
    assign rsp_nppn_o      = '0;
    assign rsp_nid_o       = '0;
`endif

    // Upper DC bits beyond the page-number width carry no meaning here.
    logic unused_dc_bits;
    assign unused_dc_bits = ^{msiptp_i[59:PPN_W], msi_addr_mask_i[63:PPN_W],
                              msi_addr_pattern_i[63:PPN_W]};

endmodule

// File: doc/iommu_msi_ptw.md
Name: iommu_msi_ptw

Overview:
- MSI address-translation walker for the IOMMU translation path. It sits directly downstream of device-context fetch.
- Consumes the extended-format DC fields msiptp, msi_addr_mask and msi_addr_pattern, plus one guest-physical write address per request.
- Decides whether the address targets a virtual interrupt file, fetches the 16-byte MSI PTE from memory and checks it.
- Returns either a translated supervisor-physical address, a pass-through indication for normal second-stage translation, or an IOMMU fault CAUSE.

Parameters:
- PLEN, 56, physical/guest-physical address width; page-number width is PLEN-12 = 44.
- MSI_MODE_FLAT, 4'd1, msiptp.mode value that enables MSI translation; any other non-zero mode is a misconfiguration.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  translation request valid
- req_ready_o  out  1  block idle, can accept a request
- req_gpaddr_i  in  PLEN  guest-physical address
- req_is_store_i  in  1  request is a write/AMO
- msiptp_i  in  64  msiptp_t: mode[63:60], ppn[43:0]
- msi_addr_mask_i  in  64  msi_addr_mask_t, mask[51:0]
- msi_addr_pattern_i  in  64  msi_addr_pattern_t, pattern[51:0]
- mem_req_valid_o  out  1  PTE read request
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  PLEN  8-byte-aligned PTE doubleword address
- mem_rsp_valid_i  in  1  read data valid; exactly one per accepted request
- mem_rsp_data_i  in  64  read data
- mem_rsp_err_i  in  1  access fault on read
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer accepts result
- rsp_is_msi_o  out  1  address translated by MSI PT; 0 means pass-through to stage-2
- rsp_spaddr_o  out  PLEN  translated address
- rsp_mrif_o  out  1  PTE is MRIF mode; valid only with MSI_MRIF_EN
- rsp_nppn_o  out  44  MRIF notice PPN
- rsp_nid_o  out  11  MRIF notice ID
- rsp_fault_o  out  1  fault
- rsp_cause_o  out  12  CAUSE encoding

Behaviour:
- Reset: FSM to IDLE. req_ready_o=1. mem_req_valid_o=0, rsp_valid_o=0. All rsp data outputs 0, mem_req_addr_o=0. Reset mid-walk abandons the walk; any memory response arriving afterwards in IDLE is ignored.
- Request capture: on req_valid_i && req_ready_o, all request and DC inputs are registered. Inputs are don't-care afterwards.
- States: IDLE -> CHECK -> RD0 -> WT0 -> (RD1 -> WT1) -> RESP -> IDLE.
- CHECK, one cycle, evaluated on registered values with gpn = gpaddr[PLEN-1:12]:
  - mode==0, or !is_store, or (gpn & ~mask[43:0]) != (pattern[43:0] & ~mask[43:0]): RESP with is_msi=0, fault=0, spaddr=gpaddr.
  - mode not 0 and not MSI_MODE_FLAT: fault, cause 259 (DDT_ENTRY_MISCONFIGURED).
  - Otherwise compute imsic_num by compacting the bits of (gpn & mask) into contiguous LSBs, lowest set mask bit first. PTE address = {ppn,12'h000} + (imsic_num << 4), truncated to PLEN, wraps silently.
- RD0: mem_req_valid_o=1, addr = PTE address. Holds valid and stable until mem_req_ready_i. Then WT0.
- WT0: waits for mem_rsp_valid_i, then checks in order:
  - err: cause 261.
  - v=0: cause 262.
  - m==2'b11 (write-through): if reserved_1 or reserved_2 non-zero, or c=1, cause 263. Else is_msi=1, spaddr = {ppn[43:0], gpaddr[11:0]}.
  - m==2'b01 (MRIF): handled per Optional Feature.
  - m==2'b00 / 2'b10: cause 263.
- RESP: rsp_valid_o=1, outputs stable until rsp_ready_i. Handshake returns to IDLE, and req_ready_o rises the cycle after.
- Latency: pass-through = 2 cycles from request handshake to rsp_valid_o. Write-through hit with zero-wait memory = 4 cycles.
- Fault results: is_msi=0, spaddr=0, mrif=0.
- One request in flight. Back-pressure on any handshake stalls without loss.

Optional Feature:
- Macro: MSI_MRIF_EN.
- Defined, m==2'b01 in WT0:
  - Reserved/c check on dword0 as above, with ppn field [50:4].
  - Then RD1/WT1 fetches the doubleword at PTE address+8. err: cause 261. Non-zero reserved_3/reserved_4: cause 263.
  - Success: is_msi=1, mrif=1, spaddr = {ppn[46:0], 9'h000} truncated to PLEN, nppn = dword1[53:10], nid = {dword1[60], dword1[9:0]}.
- Undefined: RD1/WT1 are not built; MRIF PTE gives cause 263; rsp_mrif_o, rsp_nppn_o, rsp_nid_o tied 0.

Test Plan:
- Write-through hit: msiptp={4'd1,0x80000}, mask=0x7, pattern=0x28000, store GPA 0x28003004; mem returns 0x24000C07 -> read addr 0x80000030; rsp is_msi=1, spaddr=0x90003004, fault=0.
- Pattern mismatch, and the same setup with req_is_store_i=0 at GPA 0x28003004: store GPA 0x29000000 -> no mem request; rsp is_msi=0, spaddr=0x29000000, 2-cycle latency; read at 0x28003004 -> no mem request, is_msi=0, spaddr=0x28003004, fault=0.
- PTE faults, same hit setup: mem_rsp_err_i=1 -> cause 261; data 0x6 -> cause 262; data 0x24000C03 (m=01) without macro -> cause 263; msiptp.mode=2 -> cause 259 with no mem request.
- Back-pressure: mem_req_ready_i low 5 cycles, then rsp_ready_i low 3 cycles -> addr stable throughout, one request issued, one response delivered.
- Reset mid-walk: assert rst_i in WT0, then drive stray mem_rsp_valid_i -> outputs at reset values, no rsp_valid_o; next request completes normally.
- With MSI_MRIF_EN, MRIF hit: dword0 v=1, m=01, ppn=0x1234; dword1 nppn=0x5, nid=0x401 -> second read at 0x80000038; rsp mrif=1, spaddr=0x246800, nppn=0x5, nid=0x401.
